// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// for a 5-stage pipeline MEM stage. 16 lines x 128 bits (4 words), each line
// carrying valid, dirty and a 24-bit tag.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cpu_addr_i/cpu_data_i  MEM-stage byte address / store data
//   cpu_memread_i/_write_i load / store request (store wins if both set)
//   cpu_data_o            load data (zero unless a read hit)
//   cpu_stall_o           pipeline freeze while a miss is being serviced
//   mem_enable_o/_write_o off-chip line request valid / 1 = line write
//   mem_addr_o/mem_data_o line-aligned address / victim line for writeback
//   mem_data_i/mem_ack_i  refill line / one-cycle completion pulse
//
// State table:
//   state        | meaning
//   ST_IDLE      | serve hits; a miss picks WRITEBACK (dirty victim) or ALLOCATE
//   ST_WRITEBACK | write the dirty victim line back, wait for ack
//   ST_ALLOCATE  | read the missed line, fill it on ack, return to IDLE
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_memread_i,
  input  logic         cpu_memwrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_data_o,
  input  logic [127:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;

  logic [1:0]   state;
  logic [1:0]   state_nxt;

  logic [15:0]  valid;
  logic [15:0]  dirty;
  logic [23:0]  tag_mem  [16];
  logic [127:0] data_mem [16];

  logic [3:0]   idx;
  logic [23:0]  tag_in;
  logic [1:0]   word_sel;
  logic         req;
  logic         is_store;
  logic         is_load;
  logic         hit;
  logic         write_hit;
  logic         fill_done;
  logic [127:0] line_rd;
  logic [31:0]  word_rd;
  logic         unused_addr_bits;

  assign idx      = cpu_addr_i[7:4];
  assign tag_in   = cpu_addr_i[31:8];
  assign word_sel = cpu_addr_i[3:2];

  // Byte offset within a word is irrelevant to a word-granular cache.
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign req      = cpu_memread_i | cpu_memwrite_i;
  assign is_store = cpu_memwrite_i;
  assign is_load  = cpu_memread_i & ~cpu_memwrite_i;
  assign hit      = req & valid[idx] & (tag_mem[idx] == tag_in);

  assign line_rd  = data_mem[idx];
  assign word_rd  = line_rd[{word_sel, 5'd0} +: 32];

  assign write_hit = (state == ST_IDLE) & hit & is_store;
  assign fill_done = (state == ST_ALLOCATE) & mem_ack_i;

  assign cpu_data_o  = (is_load & hit) ? word_rd : 32'd0;
  assign cpu_stall_o = (state != ST_IDLE) | (req & ~hit);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req & ~hit) begin
          state_nxt = (valid[idx] & dirty[idx]) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        if (mem_ack_i) state_nxt = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        if (mem_ack_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory-side outputs depend on state only (plus the held CPU address),
  // so they stay stable for the whole request until its ack cycle.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = 128'd0;
    case (state)
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_mem[idx], idx, 4'b0000};
        mem_data_o   = line_rd;
      end
      ST_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {cpu_addr_i[31:4], 4'b0000};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      valid <= 16'd0;
      dirty <= 16'd0;
    end else begin
      state <= state_nxt;
      if (fill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (write_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are not cleared; valid gates every use of them.
  // Reset still blocks a fill so an abandoned refill never lands.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill_done) begin
        data_mem[idx] <= mem_data_i;
        tag_mem[idx]  <= tag_in;
      end else if (write_hit) begin
        data_mem[idx][{word_sel, 5'd0} +: 32] <= cpu_data_i;
      end
    end
  end

endmodule
